zion_rr_onehot_arbiter: RTL
===========================

Name: zion_rr_onehot_arbiter

Overview:
- Parametrised round-robin arbiter built on first-set-bit one-hot selection.
- Generalises the fixed lowest-index priority encoder in three ways:
  - priority rotates after each completed grant;
  - a grant can be locked across multi-beat transfers;
  - a beat counter forces release after a set number of beats.
- Sits in front of shared resources (buses, memory ports) in the basic circuit library. Combinational search, registered grant.

Parameters:
- WIDTH, 8, number of requesters; must be ≥2.
- LOCK, 1, 1 = grant held until iAck&iLast; 0 = grant released on every iAck.
- MAX_BEATS, 16, forced release after this many accepted beats in one grant; 0 = unlimited; ignored when LOCK=0.
- IDX_W, $clog2(WIDTH), width of the index output (derived, not overridden).

Ports:
- iClk, input, 1, clock; all state updates on the rising edge.
- iRst, input, 1, synchronous active-high reset.
- iReq, input, WIDTH, request vector, one bit per requester.
- iAck, input, 1, current beat accepted by the resource; valid only while oVld=1.
- iLast, input, 1, final beat of the transfer; sampled only with iAck.
- oGnt, output, WIDTH, registered one-hot grant; all zeros when idle.
- oGntIdx, output, IDX_W, binary index of the set bit of oGnt; 0 when idle.
- oVld, output, 1, a grant is active (equals |oGnt).
- oForceRel, output, 1, single-cycle registered pulse: the grant was ended by MAX_BEATS rather than by iLast.

Behaviour:
- Reset (iRst=1 at an edge):
  - oGnt=0, oGntIdx=0, oVld=0, oForceRel=0.
  - Priority pointer ptr=0; beat counter cnt=0; FSM enters IDLE.
  - Reset takes priority over every other event, including mid-grant.
- Search function:
  - Rotate iReq right by ptr and select the first set bit, lowest index first.
  - Rotate the result back, giving a one-hot vector or zero.
  - Fully combinational; must work for non-power-of-2 WIDTH (wrap at WIDTH-1 → 0).
- FSM, two states:
  - IDLE:
    - If |iReq, register the search result into oGnt, set oVld=1, go to GRANT.
    - Latency: request to grant is exactly 1 cycle.
    - If iReq=0, stay in IDLE.
  - GRANT:
    - oGnt and oGntIdx are held stable.
    - iReq of the granted channel is ignored; a requester must not withdraw mid-transfer.
    - Releases on iAck&(iLast | !LOCK | (MAX_BEATS!=0 & cnt==MAX_BEATS-1)).
    - iAck without a release condition: cnt += 1; grant held.
- Release:
  - ptr = (granted index + 1) mod WIDTH; cnt = 0.
  - Search runs on the same-cycle iReq using the new ptr. If any bit is set, the next grant is registered with no idle bubble and the FSM stays in GRANT.
  - The just-released requester is eligible again, but only at lowest priority.
  - If the search result is zero, go to IDLE: oGnt=0 and oVld=0 next cycle.
  - oForceRel=1 for one cycle when the release was caused by the MAX_BEATS limit and iLast=0. When iLast and the limit coincide, oForceRel=0.
- Pointer behaviour:
  - ptr changes only on release.
  - IDLE retains ptr, so idle periods do not reset fairness.
- Invariants:
  - oGnt is always one-hot or zero.
  - oGnt is a subset of the iReq sampled at the grant decision.
  - oGntIdx is consistent with oGnt every cycle.
- Width rules: cnt is $clog2(MAX_BEATS+1) bits; it saturates and never wraps.

Test Plan:
- Reset: hold iRst 2 cycles with iReq=8'hFF → oGnt=0, oVld=0, oForceRel=0. Release reset → next cycle oGnt=8'h01, oGntIdx=0.
- Rotation: from reset, iReq=8'b1010_0100 held, iAck=iLast=1 every cycle → grants 8'h04 (idx2), 8'h20 (idx5), 8'h80 (idx7), 8'h04 again, on consecutive cycles with no bubble.
- Lock/hold (LOCK=1, MAX_BEATS=0): grant idx3; iAck=1, iLast=0 for 5 cycles while iReq=8'hFF → oGnt stays 8'h08. Then iAck&iLast → next grant 8'h10.
- Forced release (LOCK=1, MAX_BEATS=4): grant idx0; 4 iAck beats with iLast=0 → after the 4th beat oForceRel pulses 1 cycle and the grant moves to the next requester. With iLast on the 4th beat instead, oForceRel=0.
- Drain to idle: single grant 8'h02; complete with iReq=0 → next cycle oVld=0, oGnt=0. Then iReq=8'h03 → grant 8'h01 (ptr=2 wraps to idx0).
- Reset mid-grant with WIDTH=5, LOCK=0: in GRANT at idx4, assert iRst alongside iAck → outputs 0 and ptr=0 next cycle. Then iReq=5'b10001 → grant idx0, verifying non-power-of-2 wrap.

Source files
------------

// File: rtl/zion_rr_onehot_arbiter.sv
// Round-robin one-hot arbiter with optional grant lock and beat limit.
// Combinational rotated first-set search, registered grant.
module zion_rr_onehot_arbiter #(
   parameter int WIDTH     = 8,
   parameter int LOCK      = 1,
   parameter int MAX_BEATS = 16,
   parameter int IDX_W     = $clog2(WIDTH)
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [WIDTH-1:0] iReq,
   input  logic             iAck,
   input  logic             iLast,
   output logic [WIDTH-1:0] oGnt,
   output logic [IDX_W-1:0] oGntIdx,
   output logic             oVld,
   output logic             oForceRel
);

   localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
   localparam bit LIMIT_EN = (LOCK != 0) && (MAX_BEATS != 0);
   localparam bit NO_LOCK  = (LOCK == 0);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frel_q, frel_d;

   logic [IDX_W-1:0] ptr_rel;
   logic [IDX_W-1:0] srch_ptr;
   logic [IDX_W:0]   srch_res;
   logic             srch_hit;
   logic [IDX_W-1:0] srch_idx;
   logic [WIDTH-1:0] srch_oh;
   logic             at_limit;
   logic             rel;

   // Walk from the highest offset down so the last hit is the first from ptr.
   function automatic logic [IDX_W:0] search(
      input logic [WIDTH-1:0] req,
      input logic [IDX_W-1:0] ptr
   );
      logic [IDX_W:0] res;
      int             p;
      res = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         p = int'(ptr) + k;
         if (p >= WIDTH) p = p - WIDTH;
         if (req[IDX_W'(p)]) res = {1'b1, IDX_W'(p)};
      end
      return res;
   endfunction

   assign ptr_rel  = (int'(idx_q) == WIDTH - 1) ? '0 : idx_q + 1'b1;
   assign srch_ptr = (state_q == GRANT) ? ptr_rel : ptr_q;
   assign srch_res = search(iReq, srch_ptr);
   assign srch_hit = srch_res[IDX_W];
   assign srch_idx = srch_res[IDX_W-1:0];
   assign srch_oh  = srch_hit ? (WIDTH'(1) << srch_idx) : '0;

   assign at_limit = LIMIT_EN && (cnt_q == CNT_LAST);
   assign rel      = iLast | NO_LOCK | at_limit;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      frel_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (srch_hit) begin
               state_d = GRANT;
               gnt_d   = srch_oh;
               idx_d   = srch_idx;
            end
         end
         GRANT: begin
            if (iAck && rel) begin
               ptr_d  = ptr_rel;
               cnt_d  = '0;
               frel_d = at_limit & ~iLast;
               gnt_d  = srch_oh;
               idx_d  = srch_idx;
               if (!srch_hit) state_d = IDLE;
            end else if (iAck && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         frel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         frel_q  <= frel_d;
      end
   end

   assign oGnt      = gnt_q;
   assign oGntIdx   = idx_q;
   assign oVld      = |gnt_q;
   assign oForceRel = frel_q;

endmodule
